// File: rtl/rocketcpu_param_smoother_if.sv
// Parameter-smoother bus: sample tick, flattened targets in, smoothed values and status out.
// The i_snap lane exists only when PARAM_SMOOTHER_SNAP_EN is defined.
interface rocketcpu_param_smoother_if #(
    parameter int unsigned CHANNELS = 16,
    parameter int unsigned WIDTH    = 32
);
    logic                        i_sample_tick;
    logic [CHANNELS*WIDTH-1:0]   i_target;
    logic [CHANNELS*WIDTH-1:0]   o_value;
    logic                        o_busy;
    logic                        o_update;
    logic                        o_overrun;
`ifdef PARAM_SMOOTHER_SNAP_EN
    logic [CHANNELS-1:0]         i_snap;

    modport master (output i_sample_tick, i_target, i_snap,
                    input  o_value, o_busy, o_update, o_overrun);
    modport slave  (input  i_sample_tick, i_target, i_snap,
                    output o_value, o_busy, o_update, o_overrun);
`else
    modport master (output i_sample_tick, i_target,
                    input  o_value, o_busy, o_update, o_overrun);
    modport slave  (input  i_sample_tick, i_target,
                    output o_value, o_busy, o_update, o_overrun);
`endif
endinterface

// File: rtl/rocketcpu_param_smoother.sv
// Per-sample one-pole smoother for CPU-written audio parameters; one shared
// subtract/shift/add unit is swept across the channels. Optional per-channel bypass: PARAM_SMOOTHER_SNAP_EN.
module rocketcpu_param_smoother #(
    parameter int unsigned CHANNELS = 16,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SHIFT    = 4
) (
    input  logic                          i_wb_clk,
    input  logic                          reset,
    rocketcpu_param_smoother_if.slave     bus
);
    localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pending_q, pending_d;
    logic             update_q, update_d;
    logic             overrun_q, overrun_d;
    logic             wr_en;
    logic [WIDTH-1:0] value_q [CHANNELS];

    logic [WIDTH-1:0]        cur, tgt, new_val;
    logic signed [WIDTH:0]   diff, step, sum;
    logic                    last;

    // Shared datapath: operands are muxed from the channel under the index.
    always_comb begin
        cur  = value_q[idx_q];
        tgt  = bus.i_target[32'(idx_q)*WIDTH +: WIDTH];
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        step = diff >>> SHIFT;
        // A zero step on a nonzero difference would stall short of the target.
        if (step == '0 && diff != '0)
            step = diff[WIDTH] ? '1 : (WIDTH+1)'(1);
        sum     = $signed({1'b0, cur}) + step;
        new_val = sum[WIDTH-1:0];
`ifdef PARAM_SMOOTHER_SNAP_EN
        if (bus.i_snap[idx_q])
            new_val = tgt;
`endif
    end

    assign last = (idx_q == IDX_W'(CHANNELS - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        update_d  = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_sample_tick) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end
            end
            ST_SWEEP: begin
                wr_en = 1'b1;
                if (bus.i_sample_tick && pending_q)
                    overrun_d = 1'b1;
                if (last) begin
                    update_d  = 1'b1;
                    idx_d     = '0;
                    pending_d = 1'b0;
                    // A tick on the final channel cycle chains the next sweep directly.
                    state_d   = (pending_q || bus.i_sample_tick) ? ST_SWEEP : ST_IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    if (bus.i_sample_tick)
                        pending_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_wb_clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            update_q  <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < int'(CHANNELS); k++)
                value_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            update_q  <= update_d;
            overrun_q <= overrun_d;
            if (wr_en)
                value_q[idx_q] <= new_val;
        end
    end

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_out
        assign bus.o_value[g*WIDTH +: WIDTH] = value_q[g];
    end

    assign bus.o_busy    = (state_q == ST_SWEEP);
    assign bus.o_update  = update_q;
    assign bus.o_overrun = overrun_q;
endmodule

// File: doc/rocketcpu_param_smoother.md
Name: rocketcpu_param_smoother

Overview:
- Sits directly downstream of the CPU's memory-mapped audio parameter outputs (param_1..param_16) and upstream of the audio datapath.
- Once per audio sample tick, moves each output value a fraction of the way towards its CPU-written target. This removes zipper noise from abrupt parameter writes.
- One shared subtract/shift/add unit is time-multiplexed across all channels, one channel per clock.

Parameters:
- CHANNELS, 16: number of parameter channels; 1..64.
- WIDTH, 32: bits per parameter value.
- SHIFT, 4: smoothing coefficient; step = difference >>> SHIFT; 0..WIDTH-1.

Ports:
- i_wb_clk  in  1  system clock (12 MHz).
- reset  in  1  synchronous, active-high reset.
- i_sample_tick  in  1  one-cycle pulse at the audio sample rate.
- i_target  in  CHANNELS*WIDTH  flattened targets; channel k occupies bits [k*WIDTH +: WIDTH]; unsigned.
- o_value  out  CHANNELS*WIDTH  flattened smoothed values; same packing; registered.
- o_busy  out  1  high while a sweep is in progress.
- o_update  out  1  one-cycle pulse when a sweep completes.
- o_overrun  out  1  sticky error flag; cleared only by reset.
- i_snap  in  CHANNELS  per-channel bypass; present only with PARAM_SMOOTHER_SNAP_EN.

Behaviour:
- Clock and reset: one clock, i_wb_clk. reset is synchronous and active-high.
- Reset values: all o_value channels 0, o_busy 0, o_update 0, o_overrun 0, pending 0, state IDLE, channel index 0.
- States:
  - IDLE: if i_sample_tick is sampled high, go to SWEEP with idx=0.
  - SWEEP: on each edge, update channel idx, then idx++. After updating channel CHANNELS-1, o_update goes high for exactly one cycle.
  - End of sweep: if pending=1, clear pending and go straight to SWEEP with idx=0 (no IDLE cycle). Otherwise go to IDLE.
- Latency: tick sampled at edge 0 → channel k written at edge k+1 → o_update high in the cycle after edge CHANNELS. o_busy = (state==SWEEP).
- Per-channel arithmetic, for channel idx only:
  - diff = {1'b0,tgt} - {1'b0,cur}, signed, WIDTH+1 bits.
  - step = diff >>> SHIFT.
  - If step==0 and diff!=0, force step = +1 or -1 by the sign of diff. This guarantees exact convergence.
  - cur <= cur + step, truncated to WIDTH bits.
  - No overshoot or wrap is possible by construction, including tgt=all-ones with cur=0.
- Target sampling: i_target[idx] is read in the same cycle that channel is processed. A target change mid-sweep takes effect for any channel not yet processed.
- Channels other than idx hold their value.
- Tick during SWEEP: sets pending.
- Tick while pending is already 1: o_overrun is set and the extra tick is dropped.
- Tick coinciding with the final channel cycle: counts as pending, so the next sweep starts immediately.
- Reset mid-sweep: sweep aborts, and all registers return to their reset values on that edge.
- Tick arriving in the same cycle as reset: ignored.
- Timing constraint: CHANNELS must be less than the clock cycles per sample (250 at 48 kHz), so overrun flags a system fault.

Optional Feature:
- Macro: PARAM_SMOOTHER_SNAP_EN.
- Defined:
  - Port i_snap exists.
  - When channel idx is processed with i_snap[idx]=1, cur <= tgt in one step with no smoothing. Intended for discrete params such as waveform select.
- Undefined:
  - Port i_snap is absent.
  - All channels are always smoothed.
  - No snap logic is synthesised.

Test Plan (CHANNELS=16, WIDTH=32, SHIFT=4 unless noted):
1. After reset, set ch0 target 0x100 and pulse tick once → o_busy high for 16 cycles; ch0 = 0x10 after edge 1; o_update pulses once after edge 16; all other channels stay 0.
2. ch3: cur 0, target 5, 5 ticks → values 1,2,3,4,5 (forced ±1 path); a 6th tick leaves 5. Then target 0x100, cur 0x100 → unchanged.
3. ch7: cur 0x100, target 0 → 0xF0 after one tick. Separately, cur 0, target 0xFFFFFFFF → 0x0FFFFFFF, with no wrap.
4. Tick at the sweep's 5th cycle → o_busy stays high for 32 consecutive cycles, o_update pulses twice, o_overrun=0. Two ticks in one sweep → o_overrun=1 and it stays set until reset.
5. Assert reset at the 8th sweep cycle with targets 0x1000 → all o_value=0, o_busy=0, o_update never pulses. The next tick starts a clean sweep from ch0.
6. With PARAM_SMOOTHER_SNAP_EN, i_snap[2]=1, target 0xDEADBEEF, one tick → ch2=0xDEADBEEF after edge 3; ch1 with the same target and snap 0 → 0x0DEADBEE.
